melody_recorder: RTL and testbench

//  Encoder side of the two-channel melody byte stream played by the ok8 CPU. Watches two live
//  6-bit note selections and writes the stream into melody memory: note byte {2'bCC,note[5:0]}
//  (CC=00 ch1, 01 ch2), delay byte {1'b1,ticks[6:0]}. Sits between a note source and the

---
 rtl/ok8_melody_pkg.sv | 36 +++
 rtl/melody_recorder_tick_divider.sv | 30 +++
 rtl/melody_recorder.sv | 176 +++++++++++++++++
 tb/tb_melody_recorder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ok8_melody_pkg.sv
// Shared definitions for the ok8 two-channel melody byte stream.
// Imported by both the player and the recorder.
package ok8_melody_pkg;

    localparam logic [1:0] CH1_CODE     = 2'b00;
    localparam logic [1:0] CH2_CODE     = 2'b01;
    localparam logic [7:0] DLY_FLAG     = 8'h80;
    localparam logic [6:0] MAX_DLY      = 7'h7F;
    localparam int         DEF_TICK_DIV = 800032;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_INIT1,
        ST_INIT2,
        ST_REC,
        ST_EMIT_DLY,
        ST_EMIT_N1,
        ST_EMIT_N2,
        ST_FLUSH,
        ST_DONE
    } melody_state_e;

    typedef struct packed {
        logic       en;
        logic [7:0] data;
    } wr_req_t;

    function automatic logic [7:0] note_byte(input logic [1:0] cc, input logic [5:0] note);
        return {cc, note};
    endfunction

    function automatic logic [7:0] dly_byte(input logic [6:0] ticks);
        return DLY_FLAG | {1'b0, ticks};
    endfunction

endpackage

// File: rtl/melody_recorder_tick_divider.sv
// Delay-tick generator: one-cycle tick every TICK_DIV enabled cycles.
// The count restarts from zero whenever the enable drops.
module tick_divider
    import ok8_melody_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk12,
    input  logic n_reset,
    input  logic en,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk12 or negedge n_reset) begin
        if (!n_reset)
            cnt <= '0;
        else if (!en || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/melody_recorder.sv
// Melody stream encoder: turns two live note selections into note/delay bytes
// and writes them sequentially into melody RAM.
module melody_recorder
    import ok8_melody_pkg::*;
#(
    parameter int         TICK_DIV  = DEF_TICK_DIV,
    parameter logic [7:0] BASE_ADDR = 8'h10,
    parameter logic [7:0] END_ADDR  = 8'h63
) (
    input  logic       clk12,
    input  logic       n_reset,
    input  logic       start,
    input  logic       stop,
    input  logic [5:0] ch1_note,
    input  logic [5:0] ch2_note,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       full,
    output logic [7:0] rec_len
);

    melody_state_e state, state_nxt, emit_end;
    logic [5:0]    last1, last2, last1_nxt, last2_nxt;
    logic [6:0]    ticks, ticks_nxt, ticks_inc;
    logic          stop_pend, stop_nxt;
    logic          d1_pend, d2_pend, d1p_nxt, d2p_nxt;
    logic          d1, d2, tick, accept, div_en;
    logic [7:0]    next_addr;
    wr_req_t       req;

    assign accept    = (state == ST_IDLE) && start;
    assign div_en    = (state != ST_IDLE) && (state != ST_DONE);
    // wr_addr advances the cycle after each strobe, so this is where the next byte lands
    assign next_addr = wr_addr + {7'd0, wr_en};
    assign d1        = (ch1_note != last1);
    assign d2        = (ch2_note != last2);
    assign ticks_inc = (ticks == MAX_DLY) ? MAX_DLY : ticks + 7'd1;
    assign emit_end  = (stop_pend || stop) ? ST_FLUSH : ST_REC;

    tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk12   (clk12),
        .n_reset (n_reset),
        .en      (div_en),
        .tick    (tick)
    );

    always_comb begin
        state_nxt = state;
        req       = '0;
        ticks_nxt = ticks;
        last1_nxt = last1;
        last2_nxt = last2;
        d1p_nxt   = d1_pend;
        d2p_nxt   = d2_pend;
        stop_nxt  = stop_pend;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_INIT1;
                    last1_nxt = ch1_note;
                    last2_nxt = ch2_note;
                    ticks_nxt = '0;
                    stop_nxt  = 1'b0;
                end
            end
            ST_INIT1: begin
                req       = '{en: 1'b1, data: note_byte(CH1_CODE, last1)};
                state_nxt = ST_INIT2;
                if (tick) ticks_nxt = ticks_inc;
            end
            ST_INIT2: begin
                req       = '{en: 1'b1, data: note_byte(CH2_CODE, last2)};
                state_nxt = ST_REC;
                if (tick) ticks_nxt = ticks_inc;
            end
            ST_REC: begin
                stop_nxt = stop_pend | stop;
                if (tick) begin
                    if (ticks == MAX_DLY) begin
                        req       = '{en: 1'b1, data: dly_byte(MAX_DLY)};
                        ticks_nxt = '0;
                    end else begin
                        ticks_nxt = ticks + 7'd1;
                    end
                end
                if (d1 || d2) begin
                    last1_nxt = ch1_note;
                    last2_nxt = ch2_note;
                    d1p_nxt   = d1;
                    d2p_nxt   = d2;
                    if (ticks_nxt != '0)
                        state_nxt = ST_EMIT_DLY;
                    else if (d1)
                        state_nxt = ST_EMIT_N1;
                    else
                        state_nxt = ST_EMIT_N2;
                end else if (stop) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_EMIT_DLY: begin
                req       = '{en: 1'b1, data: dly_byte(ticks)};
                ticks_nxt = tick ? 7'd1 : 7'd0;
                stop_nxt  = stop_pend | stop;
                state_nxt = d1_pend ? ST_EMIT_N1 : (d2_pend ? ST_EMIT_N2 : emit_end);
            end
            ST_EMIT_N1: begin
                req       = '{en: 1'b1, data: note_byte(CH1_CODE, last1)};
                if (tick) ticks_nxt = ticks_inc;
                stop_nxt  = stop_pend | stop;
                state_nxt = d2_pend ? ST_EMIT_N2 : emit_end;
            end
            ST_EMIT_N2: begin
                req       = '{en: 1'b1, data: note_byte(CH2_CODE, last2)};
                if (tick) ticks_nxt = ticks_inc;
                stop_nxt  = stop_pend | stop;
                state_nxt = emit_end;
            end
            ST_FLUSH: begin
                if (ticks != '0) req = '{en: 1'b1, data: dly_byte(ticks)};
                state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        // the last writable slot ends the recording, whatever was still queued
        if (req.en && (next_addr == END_ADDR)) state_nxt = ST_DONE;
    end

    always_ff @(posedge clk12 or negedge n_reset) begin
        if (!n_reset) begin
            state     <= ST_IDLE;
            last1     <= '0;
            last2     <= '0;
            ticks     <= '0;
            stop_pend <= 1'b0;
            d1_pend   <= 1'b0;
            d2_pend   <= 1'b0;
        end else begin
            state     <= state_nxt;
            last1     <= last1_nxt;
            last2     <= last2_nxt;
            ticks     <= ticks_nxt;
            stop_pend <= stop_nxt;
            d1_pend   <= d1p_nxt;
            d2_pend   <= d2p_nxt;
        end
    end

    always_ff @(posedge clk12 or negedge n_reset) begin
        if (!n_reset) begin
            wr_en   <= 1'b0;
            wr_addr <= BASE_ADDR;
            wr_data <= '0;
            busy    <= 1'b0;
            full    <= 1'b0;
            rec_len <= '0;
        end else begin
            wr_en <= req.en;
            if (req.en) wr_data <= req.data;
            wr_addr <= accept ? BASE_ADDR : next_addr;
            if (accept) begin
                busy <= 1'b1;
                full <= 1'b0;
            end
            if (req.en && (next_addr == END_ADDR)) full <= 1'b1;
            if (state == ST_DONE) begin
                busy    <= 1'b0;
                rec_len <= next_addr - BASE_ADDR;
            end
        end
    end

endmodule

// File: tb/tb_melody_recorder.sv
// Bench for melody_recorder: queue-based stream model checked every cycle,
// directed scenarios pinned with literal bytes, then randomized recordings.
module tb_melody_recorder;

    localparam int         DIV  = 4;
    localparam logic [7:0] BASE = 8'h10;
    localparam logic [7:0] ENDA = 8'h63;
    localparam int         DLY_TOKEN = 256;

    logic       clk12, n_reset, start, stop;
    logic [5:0] ch1_note, ch2_note;
    logic       wr_en, busy, full;
    logic [7:0] wr_addr, wr_data, rec_len;

    melody_recorder #(.TICK_DIV(DIV), .BASE_ADDR(BASE), .END_ADDR(ENDA)) dut (
        .clk12    (clk12),
        .n_reset  (n_reset),
        .start    (start),
        .stop     (stop),
        .ch1_note (ch1_note),
        .ch2_note (ch2_note),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .full     (full),
        .rec_len  (rec_len)
    );

    initial clk12 = 1'b0;
    always #5 clk12 = ~clk12;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  addr;
        logic [7:0]  data;
    } ent_t;
    ent_t wlog[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic ent_t ent(input int i);
        ent_t e;
        e = '0;
        if (i < wlog.size()) e = wlog[i];
        return e;
    endfunction

    task automatic chk_ent(input string nm, input int i, input logic [7:0] a, input logic [7:0] d);
        ent_t e;
        e = ent(i);
        chk({nm, "_addr"}, 32'(e.addr), 32'(a));
        chk({nm, "_data"}, 32'(e.data), 32'(d));
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 recording (queue drains one byte per cycle, empty queue = watching),
    // 2 flush, 3 done
    int         phase, init_left, mticks, ecnt;
    int         q[$];
    logic [5:0] l1, l2;
    bit         spend, m_full, m_busy, x_en;
    logic [7:0] ptr, m_len, x_data, x_addr;

    task automatic m_reset();
        phase = 0; init_left = 0; mticks = 0; ecnt = 0; q.delete();
        l1 = '0; l2 = '0; spend = 0; m_full = 0; m_busy = 0; x_en = 0;
        ptr = BASE; m_len = '0; x_data = '0; x_addr = BASE;
    endtask

    task automatic issue(input logic [7:0] b);
        x_en = 1; x_data = b; x_addr = ptr; ptr = ptr + 8'd1;
        if (x_addr == ENDA) begin
            m_full = 1; phase = 3; q.delete();
        end
    endtask

    task automatic m_step();
        bit tick, d1, d2, sat;
        int b;
        x_en = 0;
        tick = 0;
        if (phase == 1 || phase == 2) begin
            tick = (ecnt == DIV - 1);
            ecnt = tick ? 0 : ecnt + 1;
        end
        case (phase)
            0: if (start) begin
                phase = 1; m_busy = 1; m_full = 0; ptr = BASE;
                mticks = 0; ecnt = 0; spend = 0; init_left = 2;
                l1 = ch1_note; l2 = ch2_note;
                q.delete();
                q.push_back(int'({2'b00, ch1_note}));
                q.push_back(int'({2'b01, ch2_note}));
            end
            1: if (q.size() > 0) begin
                b = q.pop_front();
                if (init_left > 0) init_left--;
                else if (stop) spend = 1;
                if (b == DLY_TOKEN) begin
                    issue({1'b1, mticks[6:0]});
                    mticks = tick ? 1 : 0;
                end else begin
                    issue(b[7:0]);
                    if (tick && mticks < 127) mticks++;
                end
                if (phase == 1 && q.size() == 0 && spend) phase = 2;
            end else begin
                sat = 0;
                if (tick) begin
                    if (mticks == 127) begin sat = 1; mticks = 0; end
                    else mticks++;
                end
                d1 = (ch1_note != l1);
                d2 = (ch2_note != l2);
                if (d1 || d2) begin
                    if (mticks > 0) q.push_back(DLY_TOKEN);
                    if (d1) q.push_back(int'({2'b00, ch1_note}));
                    if (d2) q.push_back(int'({2'b01, ch2_note}));
                    l1 = ch1_note; l2 = ch2_note;
                    if (stop) spend = 1;
                end else if (stop) begin
                    phase = 2;
                end
                if (sat) issue(8'hFF);
            end
            2: begin
                phase = 3;
                if (mticks > 0) issue({1'b1, mticks[6:0]});
            end
            3: begin
                m_busy = 0; m_len = ptr - BASE; phase = 0;
            end
            default: phase = 0;
        endcase
        if (!x_en) x_addr = ptr;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk12);
            cyc++;
            if (!n_reset) m_reset();
            else m_step();
        end
    end

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk12);
            if (!n_reset) begin
                chk("rst_wr_en",   32'(wr_en),   32'd0);
                chk("rst_wr_addr", 32'(wr_addr), 32'(BASE));
                chk("rst_wr_data", 32'(wr_data), 32'd0);
                chk("rst_busy",    32'(busy),    32'd0);
                chk("rst_full",    32'(full),    32'd0);
                chk("rst_rec_len", 32'(rec_len), 32'd0);
            end else begin
                chk("wr_en",   32'(wr_en),   32'(x_en));
                chk("wr_addr", 32'(wr_addr), 32'(x_addr));
                if (x_en) chk("wr_data", 32'(wr_data), 32'(x_data));
                chk("busy", 32'(busy), 32'(m_busy));
                chk("full", 32'(full), 32'(m_full));
                if (!m_busy) chk("rec_len", 32'(rec_len), 32'(m_len));
                if (wr_en) wlog.push_back('{cyc: 32'(cyc), addr: wr_addr, data: wr_data});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk12);
        start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ent_t e0, e1;
        n_reset = 1'b0; start = 1'b0; stop = 1'b0;
        ch1_note = 6'd5; ch2_note = 6'd0;
        repeat (2) @(negedge clk12);
        n_reset = 1'b1;
        @(negedge clk12);

        // 1: initial notes
        wlog.delete();
        pulse_start();
        repeat (12) @(negedge clk12);
        chk("t1_nwr", 32'(wlog.size()), 32'd2);
        chk_ent("t1_w0", 0, 8'h10, 8'h05);
        chk_ent("t1_w1", 1, 8'h11, 8'h40);
        e0 = ent(0); e1 = ent(1);
        chk("t1_b2b", e1.cyc - e0.cyc, 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);

        // 2: 3 ticks then ch1 change
        ch1_note = 6'd8;
        repeat (8) @(negedge clk12);
        chk("t2_nwr", 32'(wlog.size()), 32'd4);
        chk_ent("t2_w2", 2, 8'h12, 8'h83);
        chk_ent("t2_w3", 3, 8'h13, 8'h08);

        // 3: 2 ticks then both channels change together
        ch1_note = 6'd10; ch2_note = 6'd1;
        repeat (5) @(negedge clk12);
        chk_ent("t3_w4", 4, 8'h14, 8'h82);
        chk_ent("t3_w5", 5, 8'h15, 8'h0A);
        chk_ent("t3_w6", 6, 8'h16, 8'h41);
        e0 = ent(4); e1 = ent(6);
        chk("t3_b2b", e1.cyc - e0.cyc, 32'd2);

        // 4: long hold saturates the delay
        repeat (519) @(negedge clk12);
        ch2_note = 6'd3;
        repeat (6) @(negedge clk12);
        chk_ent("t4_sat", 7, 8'h17, 8'hFF);
        chk_ent("t4_dly", 8, 8'h18, 8'h83);
        chk_ent("t4_n2",  9, 8'h19, 8'h43);

        // 5: fill memory
        for (int k = 0; k < 1000 && busy; k++) begin
            if (k % 3 == 0) ch1_note = ch1_note ^ 6'h01;
            @(negedge clk12);
        end
        repeat (3) @(negedge clk12);
        chk("t5_full", 32'(full), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_len",  32'(rec_len), 32'h54);
        wlog.delete();
        repeat (20) @(negedge clk12);
        chk("t5_quiet", 32'(wlog.size()), 32'd0);

        // 5b: stop after 5 idle ticks flushes the delay
        pulse_start();
        chk("t5b_full_clr", 32'(full), 32'd0);
        repeat (20) @(negedge clk12);
        stop = 1'b1;
        @(negedge clk12);
        stop = 1'b0;
        repeat (5) @(negedge clk12);
        chk_ent("t5b_flush", 2, 8'h12, 8'h85);
        chk("t5b_busy", 32'(busy), 32'd0);
        chk("t5b_len",  32'(rec_len), 32'd3);

        // 6: reset between delay and note write
        ch1_note = 6'd1; ch2_note = 6'd2;
        pulse_start();
        repeat (10) @(negedge clk12);
        ch1_note = 6'd7;
        for (int k = 0; k < 20 && !(wr_en && wr_data[7]); k++) @(negedge clk12);
        chk("t6_dly_seen", {wr_en, wr_data}, {1'b1, 8'h82});
        #1 n_reset = 1'b0;
        #1;
        chk("t6_wr_en",   32'(wr_en),   32'd0);
        chk("t6_wr_addr", 32'(wr_addr), 32'(BASE));
        chk("t6_wr_data", 32'(wr_data), 32'd0);
        chk("t6_busy",    32'(busy),    32'd0);
        @(negedge clk12);
        n_reset = 1'b1;
        wlog.delete();
        pulse_start();
        repeat (4) @(negedge clk12);
        chk_ent("t6_re0", 0, 8'h10, 8'h07);
        chk_ent("t6_re1", 1, 8'h11, 8'h42);
        stop = 1'b1;
        @(negedge clk12);
        stop = 1'b0;
        repeat (4) @(negedge clk12);

        // randomized recordings
        for (int r = 0; r < 30; r++) begin
            int rate;
            rate = (r % 3 == 0) ? 400 : 6;
            ch1_note = 6'($urandom_range(0, 63));
            ch2_note = 6'($urandom_range(0, 63));
            stop = 1'b1;
            @(negedge clk12);
            stop = 1'b0;
            pulse_start();
            for (int c = 0; c < 1500 && busy; c++) begin
                if ($urandom_range(0, rate - 1) == 0) ch1_note = 6'($urandom_range(0, 63));
                if ($urandom_range(0, rate - 1) == 0) ch2_note = 6'($urandom_range(0, 63));
                start = ($urandom_range(0, 50) == 0);
                stop  = ($urandom_range(0, 300) == 0);
                @(negedge clk12);
            end
            start = 1'b0;
            stop  = busy;
            @(negedge clk12);
            stop = 1'b0;
            for (int k = 0; k < 50 && busy; k++) @(negedge clk12);
            chk("rand_end_busy", 32'(busy), 32'd0);
            repeat (3) @(negedge clk12);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
